fifo_rd_stream: RTL and testbench
=================================

// Module: fifo_rd_stream
// PURPOSE
//  Read-side adapter that sits directly downstream of the clock-crossing FIFO, in its read clock domain.
//  Drains FIFO words through the FIFO pop port (rd/empty/data) and re-presents them on a valid/ready stream.
//  Holds words in a 2-entry skid buffer, so consumers can stall freely while full throughput is kept.
//  Also provides a flush and a saturating count of delivered words.
// PARAMETERS
//  WIDTH    8   data width; must equal the FIFO WIDTH
//  CNT_W    16  width of the delivered-word counter
// PORTS
//  clk_i          in   1      read-domain clock (the FIFO rdclk_i)
//  rst_ni         in   1      asynchronous, active-low reset
//  fifo_empty_i   in   1      FIFO empty flag
//  fifo_data_i    in   WIDTH  FIFO read data; valid in the same cycle as fifo_rd_o=1 with fifo_empty_i=0
//  fifo_rd_o      out  1      FIFO pop request (drives FIFO rd_i)
//  m_valid_o      out  1      output word valid
//  m_data_o       out  WIDTH  output word
//  m_ready_i      in   1      consumer accepts the word when m_valid_o=1 and m_ready_i=1
//  flush_i        in   1      discard all buffered words this cycle
//  level_o        out  2      buffered word count, 0..2
//  word_cnt_o     out  CNT_W  words delivered (saturating)
// BEHAVIOUR
//  - Reset (async assert, sync to clk_i on release): buffer empty; level_o=0; m_valid_o=0; m_data_o=0;
//    word_cnt_o=0; run flag=0.
//  - Run flag: set at the first clk_i edge after reset release. While it is 0, fifo_rd_o=0.
//  - pop = fifo_rd_o & ~fifo_empty_i.
//  - fifo_rd_o = run & ~flush_i & (level<2), combinational from registered state plus flush_i.
//    It does not depend on m_ready_i.
//  - On a pop, fifo_data_i is captured at that clk_i edge into the tail slot (slot0 if the buffer is empty
//    or about to empty, else slot1).
//    - Latency: popped word appears on m_data_o with m_valid_o=1 one cycle after the pop cycle.
//  - m_data_o/m_valid_o are driven from the head register (slot0) only; there is no combinational path
//    from fifo_data_i.
//  - accept = m_valid_o & m_ready_i. On accept, slot1 shifts to slot0 if it is occupied.
//  - Simultaneous pop and accept: level unchanged.
//    - With level=1, the new word goes directly to slot0; this is full rate, 1 word/cycle.
//  - Level update per edge: level + pop - accept, bounded to 0..2 by construction.
//    - A pop never occurs at level=2.
//  - m_valid_o, once asserted, stays asserted with m_data_o stable until accept or flush.
//  - flush_i=1: the next edge sets level=0 and m_valid_o=0. Slots are not cleared; m_data_o holds its last value.
//    - No pop occurs in a flush cycle.
//    - An accept in the same cycle still counts in word_cnt_o.
//  - word_cnt_o increments by 1 per accept and saturates at 2^CNT_W-1 (no wrap).
//  - FIFO empty: fifo_rd_o may be 1 with fifo_empty_i=1; no pop occurs and the buffer is unchanged.
//  - Reset mid-operation: all state clears immediately; buffered words are lost.
//    - The FIFO is reset by the same event, so the two stay consistent.
// TESTING
//  1. Reset, then FIFO holds 0x11,0x22,0x33 with m_ready_i=1
//     -> fifo_rd_o=0 in the first cycle after release.
//     -> then pops on 3 consecutive cycles; m_data_o=0x11,0x22,0x33 on consecutive cycles, 1 cycle after
//        each pop; word_cnt_o=3.
//  2. m_ready_i=0 with a non-empty FIFO
//     -> exactly 2 pops, then fifo_rd_o=0 and level_o=2; m_data_o holds the first word.
//     -> Raise m_ready_i: words come out in order with no loss or duplication.
//  3. Random m_ready_i (50%) over 1000 random words from a scoreboard-driven FIFO model
//     -> output sequence equals input sequence.
//     -> No pop when level_o=2; m_data_o stable while m_valid_o=1 & ~m_ready_i.
//  4. flush_i at level_o=2 in the same cycle as an accept
//     -> next cycle level_o=0, m_valid_o=0, word_cnt_o +1.
//     -> fifo_rd_o=0 during the flush cycle.
//  5. fifo_empty_i toggled every cycle with m_ready_i=1
//     -> pops only when fifo_empty_i=0; each word appears exactly once.
//  6. CNT_W=4: deliver 20 words -> word_cnt_o=15 after the 15th accept and stays 15.
//     Assert rst_ni low mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: pops words from the clock-crossing FIFO into a 2-entry skid buffer
// and presents them on a valid/ready stream, with flush and a saturating delivered-word count.
module fifo_rd_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             fifo_empty_i,
    input  logic [WIDTH-1:0] fifo_data_i,
    output logic             fifo_rd_o,
    output logic             m_valid_o,
    output logic [WIDTH-1:0] m_data_o,
    input  logic             m_ready_i,
    input  logic             flush_i,
    output logic [1:0]       level_o,
    output logic [CNT_W-1:0] word_cnt_o
);

    logic             run_q;
    logic [1:0]       level_q, level_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] slot0_q, slot0_d;
    logic [WIDTH-1:0] slot1_q, slot1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pop;
    logic             accept;

    // Pop request never looks at m_ready_i; the second slot absorbs a stall.
    assign fifo_rd_o = run_q & ~flush_i & (level_q != 2'd2);
    assign pop       = fifo_rd_o & ~fifo_empty_i;
    assign accept    = valid_q & m_ready_i;

    always_comb begin
        level_d = level_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        cnt_d   = cnt_q;

        if (flush_i) begin
            level_d = 2'd0;
        end else begin
            level_d = level_q + {1'b0, pop} - {1'b0, accept};
            if (accept && level_q == 2'd2) begin
                slot0_d = slot1_q;
            end
            // New word goes to the head slot when the buffer is empty or draining this cycle.
            if (pop) begin
                if (level_q == 2'd0 || (level_q == 2'd1 && accept)) begin
                    slot0_d = fifo_data_i;
                end else begin
                    slot1_d = fifo_data_i;
                end
            end
        end

        valid_d = (level_d != 2'd0);

        if (accept && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q   <= 1'b0;
            level_q <= 2'd0;
            valid_q <= 1'b0;
            slot0_q <= '0;
            slot1_q <= '0;
            cnt_q   <= '0;
        end else begin
            run_q   <= 1'b1;
            level_q <= level_d;
            valid_q <= valid_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign m_valid_o  = valid_q;
    assign m_data_o   = slot0_q;
    assign level_o    = level_q;
    assign word_cnt_o = cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based FIFO source and buffer model, directed and random steps,
// counter instantiated narrow so saturation is reachable.
module tb_fifo_rd_stream;

    localparam int WIDTH   = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_ni = 1'b1;
    logic             fifo_empty_i = 1'b1;
    logic [WIDTH-1:0] fifo_data_i = '0;
    logic             fifo_rd_o;
    logic             m_valid_o;
    logic [WIDTH-1:0] m_data_o;
    logic             m_ready_i = 1'b0;
    logic             flush_i = 1'b0;
    logic [1:0]       level_o;
    logic [CNT_W-1:0] word_cnt_o;

    fifo_rd_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .fifo_empty_i (fifo_empty_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_rd_o    (fifo_rd_o),
        .m_valid_o    (m_valid_o),
        .m_data_o     (m_data_o),
        .m_ready_i    (m_ready_i),
        .flush_i      (flush_i),
        .level_o      (level_o),
        .word_cnt_o   (word_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WIDTH-1:0] src[$];       // words waiting in the upstream FIFO
    logic [WIDTH-1:0] mq[$];        // words held by the adapter, head first
    logic [WIDTH-1:0] got[$];       // words the consumer actually took
    logic [WIDTH-1:0] exp_words[$]; // words the consumer should have taken
    logic [WIDTH-1:0] held = '0;
    int               cnt = 0;
    bit               run = 1'b0;
    bit               force_empty = 1'b0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        #3 rst_ni = 1'b0;
        mq.delete(); src.delete();
        held = '0; cnt = 0; run = 1'b0;
        #1;
        chk("rst_rd", fifo_rd_o, 0);
        chk("rst_valid", m_valid_o, 0);
        chk("rst_data", m_data_o, 0);
        chk("rst_level", level_o, 0);
        chk("rst_cnt", word_cnt_o, 0);
        @(posedge clk); @(posedge clk);
        #3 rst_ni = 1'b1;
    endtask

    // One clock cycle: drive the FIFO, compare outputs to the model, then advance the model.
    task automatic cycle();
        bit exp_rd, pop, acc;
        fifo_empty_i = force_empty || (src.size() == 0);
        fifo_data_i  = fifo_empty_i ? WIDTH'($urandom) : src[0];
        #1;
        exp_rd = run && !flush_i && (mq.size() < 2);
        chk("rd", fifo_rd_o, exp_rd);
        chk("valid", m_valid_o, mq.size() > 0);
        chk("data", m_data_o, (mq.size() > 0) ? mq[0] : held);
        chk("level", level_o, mq.size());
        chk("cnt", word_cnt_o, cnt);
        if (m_valid_o && m_ready_i) got.push_back(m_data_o);
        pop = exp_rd && !fifo_empty_i;
        acc = (mq.size() > 0) && m_ready_i;
        @(posedge clk);
        if (acc) begin
            void'(mq.pop_front());
            if (cnt < CNT_MAX) cnt++;
        end
        if (flush_i) mq.delete();
        if (pop) mq.push_back(src.pop_front());
        if (mq.size() > 0) held = mq[0];
        run = 1'b1;
        #1;
    endtask

    task automatic drain(int max_cycles);
        int n = 0;
        while ((src.size() > 0 || mq.size() > 0) && n < max_cycles) begin
            cycle();
            n++;
        end
        chk("drain_timeout", (src.size() > 0 || mq.size() > 0), 0);
    endtask

    task automatic check_got(string tag);
        int bad = 0;
        chk({tag, "_count"}, got.size(), exp_words.size());
        for (int i = 0; i < got.size() && i < exp_words.size(); i++)
            if (got[i] !== exp_words[i]) bad++;
        chk({tag, "_order"}, bad, 0);
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        int n;

        // 1: three words at full rate
        do_reset();
        m_ready_i = 1'b1;
        src = '{8'h11, 8'h22, 8'h33};
        exp_words = '{8'h11, 8'h22, 8'h33};
        got.delete();
        drain(20);
        cycle();
        check_got("t1");
        chk("t1_cnt", word_cnt_o, 3);

        // 2: stalled consumer fills exactly two slots
        m_ready_i = 1'b0;
        got.delete(); exp_words.delete();
        for (int i = 0; i < 4; i++) begin
            w = WIDTH'($urandom);
            src.push_back(w);
            exp_words.push_back(w);
        end
        repeat (5) cycle();
        chk("t2_level", level_o, 2);
        chk("t2_rd", fifo_rd_o, 0);
        chk("t2_head", m_data_o, exp_words[0]);
        m_ready_i = 1'b1;
        drain(20);
        check_got("t2");

        // 3: random ready and FIFO gaps over 1000 words
        got.delete(); exp_words.delete();
        for (int i = 0; i < 1000; i++) begin
            w = WIDTH'($urandom);
            src.push_back(w);
            exp_words.push_back(w);
        end
        n = 0;
        while ((src.size() > 0 || mq.size() > 0) && n < 6000) begin
            m_ready_i   = $urandom_range(0, 1) == 1;
            force_empty = $urandom_range(0, 3) == 0;
            cycle();
            n++;
        end
        force_empty = 1'b0;
        chk("t3_timeout", (src.size() > 0 || mq.size() > 0), 0);
        check_got("t3");

        // 4: flush at level 2 together with an accept
        do_reset();
        m_ready_i = 1'b0;
        src = '{8'hA1, 8'hA2, 8'hA3};
        repeat (4) cycle();
        chk("t4_full", level_o, 2);
        flush_i = 1'b1; m_ready_i = 1'b1;
        #1 chk("t4_rd_flush", fifo_rd_o, 0);
        cycle();
        flush_i = 1'b0; m_ready_i = 1'b0;
        chk("t4_level", level_o, 0);
        chk("t4_valid", m_valid_o, 0);
        chk("t4_cnt", word_cnt_o, 1);
        chk("t4_hold", m_data_o, 8'hA1);
        src.delete();

        // 5: FIFO empty flag toggling every cycle
        m_ready_i = 1'b1;
        got.delete(); exp_words.delete();
        for (int i = 0; i < 6; i++) begin
            w = WIDTH'($urandom);
            src.push_back(w);
            exp_words.push_back(w);
        end
        n = 0;
        while ((src.size() > 0 || mq.size() > 0) && n < 40) begin
            force_empty = ~force_empty;
            cycle();
            n++;
        end
        force_empty = 1'b0;
        chk("t5_timeout", (src.size() > 0 || mq.size() > 0), 0);
        check_got("t5");

        // 6: counter saturation, then reset mid-stream
        do_reset();
        m_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) src.push_back(WIDTH'($urandom));
        drain(60);
        chk("t6_sat", word_cnt_o, CNT_MAX);
        for (int i = 0; i < 6; i++) src.push_back(WIDTH'($urandom));
        m_ready_i = 1'b0;
        repeat (3) cycle();
        chk("t6_pre_level", level_o, 2);
        do_reset();
        repeat (2) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
